// File: rtl/mont_inv_pkg.sv
// Shared types and helpers for the Montgomery-domain modular inverter.
// Provides the FSM state encoding, the fixed latency function and a width helper.
package mont_inv_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPh1,
        StFix,
        StPh2,
        StDone
    } state_e;

    // Edges from the accepting edge to the rise of out_valid.
    function automatic int unsigned lat(input int unsigned e);
        return 2 * e + 3;
    endfunction

    function automatic int unsigned clog2(input int unsigned x);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(x)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/kaliski_step.sv
// One combinational Kaliski almost-inverse step on (u, v, r, s).
// The caller decides when to stop (v == 0); this block only computes the next tuple.
module kaliski_step #(
    parameter int unsigned WIDTH = 446
) (
    input  logic [WIDTH-1:0] u_i,
    input  logic [WIDTH-1:0] v_i,
    input  logic [WIDTH:0]   r_i,
    input  logic [WIDTH:0]   s_i,
    input  logic [WIDTH-1:0] p_i,
    output logic [WIDTH-1:0] u_o,
    output logic [WIDTH-1:0] v_o,
    output logic [WIDTH:0]   r_o,
    output logic [WIDTH:0]   s_o
);

    always_comb begin
        u_o = u_i;
        v_o = v_i;
        r_o = r_i;
        s_o = s_i;
        if (!u_i[0]) begin
            u_o = u_i >> 1;
            s_o = s_i << 1;
        end else if (!v_i[0]) begin
            v_o = v_i >> 1;
            r_o = r_i << 1;
        end else if (u_i > v_i) begin
            u_o = (u_i - v_i) >> 1;
            r_o = r_i + s_i;
            s_o = s_i << 1;
        end else begin
            v_o = (v_i - u_i) >> 1;
            s_o = s_i + r_i;
            r_o = r_i << 1;
        end
    end

    // u starts at p and only ever shrinks.
    always_comb begin
        assert (u_i <= p_i);
    end

endmodule

// File: rtl/mont_inverter_hs.sv
// Constant-latency Montgomery-domain inverter: Mont(a) in, Mont(a^-1) out.
// Kaliski almost-inverse gives a'^-1 * 2^k, then 2E-k doublings land on a^-1 * 2^E.
`ifndef CHAR
`define CHAR 446'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff
`endif

module mont_inverter_hs
    import mont_inv_pkg::*;
#(
    parameter int unsigned       WIDTH    = 446,
    parameter logic [WIDTH-1:0]  MODULUS  = `CHAR,
    parameter int unsigned       MONT_EXP = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    localparam int unsigned    KW    = clog2(2 * MONT_EXP + 1);
    localparam logic [KW-1:0]  TWO_E = KW'(2 * MONT_EXP);
    localparam logic [WIDTH:0] P_EXT = {1'b0, MODULUS};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] u_q, u_d, v_q, v_d;
    logic [WIDTH:0]   r_q, r_d, s_q, s_d;
    logic [KW-1:0]    k_q, k_d, cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_err_q, out_err_d;

    logic [WIDTH-1:0] u_step, v_step;
    logic [WIDTH:0]   r_step, s_step;
    logic             bad_operand;
    logic [WIDTH:0]   r_red, r_dbl, r_dbl_red;

    kaliski_step #(
        .WIDTH(WIDTH)
    ) u_kaliski (
        .u_i(u_q),
        .v_i(v_q),
        .r_i(r_q),
        .s_i(s_q),
        .p_i(MODULUS),
        .u_o(u_step),
        .v_o(v_step),
        .r_o(r_step),
        .s_o(s_step)
    );

    assign bad_operand = (in_data == '0) || (in_data >= MODULUS);
    assign r_red       = (r_q >= P_EXT) ? r_q - P_EXT : r_q;
    // r < p during PH2, so 2r < 2p and a single subtract suffices.
    assign r_dbl       = {r_q[WIDTH-1:0], 1'b0};
    assign r_dbl_red   = (r_dbl >= P_EXT) ? r_dbl - P_EXT : r_dbl;

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

    always_comb begin
        state_d    = state_q;
        u_d        = u_q;
        v_d        = v_q;
        r_d        = r_q;
        s_d        = s_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    u_d     = MODULUS;
                    v_d     = bad_operand ? '0 : in_data;
                    r_d     = '0;
                    s_d     = {{WIDTH{1'b0}}, 1'b1};
                    k_d     = '0;
                    err_d   = bad_operand;
                    state_d = StPh1;
                end
            end
            StPh1: begin
                if (v_q == '0) begin
                    state_d = StFix;
                end else begin
                    u_d = u_step;
                    v_d = v_step;
                    r_d = r_step;
                    s_d = s_step;
                    k_d = k_q + 1'b1;
                end
            end
            StFix: begin
                r_d     = (r_red == '0) ? '0 : P_EXT - r_red;
                cnt_d   = TWO_E - k_q;
                state_d = StPh2;
            end
            StPh2: begin
                if (cnt_q != '0) begin
                    r_d   = r_dbl_red;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    out_data_d = r_q[WIDTH-1:0];
                    out_err_d  = err_q;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            u_q        <= '0;
            v_q        <= '0;
            r_q        <= '0;
            s_q        <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            u_q        <= u_d;
            v_q        <= v_d;
            r_q        <= r_d;
            s_q        <= s_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    // The doubling count 2E-k must not underflow.
    always @(posedge clk) begin
        if (!rst && state_q == StFix) begin
            assert (k_q <= TWO_E);
        end
    end

endmodule

// File: tb/tb_mont_inverter_hs.sv
// Bench for mont_inverter_hs at WIDTH=8, p=251, E=8 against a brute-force inverse model.
module tb_mont_inverter_hs;

    localparam int P   = 251;
    localparam int R   = 256;
    localparam int LAT = 19;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_err;

    logic out_ready_man;
    logic rand_ready = 1'b0;
    logic ready_rnd  = 1'b1;
    assign out_ready = rand_ready ? ready_rnd : out_ready_man;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int data;
        int acc;
    } item_t;
    item_t q[$];
    bit    was_valid = 1'b0;
    bit    hs_prev   = 1'b0;
    int    exp_d, exp_e;

    mont_inverter_hs #(
        .WIDTH(8),
        .MODULUS(8'd251),
        .MONT_EXP(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 ready_rnd = 1'($urandom % 2);
    end

    function automatic int model_err(input int x);
        return (x == 0 || x >= P) ? 1 : 0;
    endfunction

    // Mont(a^-1) = (a*R)^-1 * R^2 mod p, inverse found by search.
    function automatic int model_data(input int x);
        int y;
        if (model_err(x) != 0) return 0;
        y = 1;
        while ((x * y) % P != 1) y++;
        return (y * ((R * R) % P)) % P;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            was_valid = 1'b0;
            hs_prev   = 1'b0;
        end else begin
            if (hs_prev) begin
                chk("in_ready_after_hs", int'(in_ready), 1);
                chk("out_valid_after_hs", int'(out_valid), 0);
                hs_prev = 1'b0;
            end
            if (out_valid) begin
                chk("in_ready_in_done", int'(in_ready), 0);
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    exp_d = model_data(q[0].data);
                    exp_e = model_err(q[0].data);
                    chk($sformatf("out_data_for_%0d", q[0].data), int'(out_data), exp_d);
                    chk($sformatf("out_err_for_%0d", q[0].data), int'(out_err), exp_e);
                    if (!was_valid) chk("latency", cyc - q[0].acc, LAT);
                    if (exp_e == 0) begin
                        chk("round_trip", (q[0].data * int'(out_data)) % P, (R * R) % P);
                    end
                    was_valid = 1'b1;
                    if (out_ready) begin
                        void'(q.pop_front());
                        was_valid = 1'b0;
                        hs_prev   = 1'b1;
                    end
                end
            end else if (q.size() != 0) begin
                chk("no_late_result", int'((cyc - q[0].acc) < LAT), 1);
            end
            if (in_valid && in_ready) q.push_back('{int'(in_data), cyc + 1});
        end
    end

    task automatic send(input int x, input bit hold);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = 8'(x);
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        chk("accept_wait", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_data  = 8'($urandom);
        in_valid = hold;
    endtask

    task automatic wait_out(output int d, output int e);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
        chk("result_wait", int'(out_valid), 1);
        d = int'(out_data);
        e = int'(out_err);
    endtask

    task automatic do_lit(input int x, input int ed, input int ee);
        int d, e;
        send(x, 1'b0);
        wait_out(d, e);
        chk($sformatf("lit_data_%0d", x), d, ed);
        chk($sformatf("lit_err_%0d", x), e, ee);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
        chk({tag, "_out_err"}, int'(out_err), 0);
    endtask

    initial begin
        int d0, e0;
        int order[256];
        int b2b[5];
        int j, t;
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        out_ready_man = 1'b1;
        #2;
        chk_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("model_pin_5", model_data(5), 5);
        chk("model_pin_10", model_data(10), 128);

        do_lit(5, 5, 0);
        do_lit(10, 128, 0);
        do_lit(0, 0, 1);
        do_lit(251, 0, 1);
        do_lit(255, 0, 1);

        // Backpressure: result must sit still while the consumer stalls.
        out_ready_man = 1'b0;
        send(7, 1'b0);
        wait_out(d0, e0);
        repeat (10) begin
            @(negedge clk);
            chk("bp_data_stable", int'(out_data), d0);
            chk("bp_err_stable", int'(out_err), e0);
            chk("bp_valid_held", int'(out_valid), 1);
            chk("bp_in_ready_low", int'(in_ready), 0);
        end
        @(posedge clk);
        #1 out_ready_man = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_after_release", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Reset in the middle of an operation.
        send(10, 1'b0);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk_reset_vals("midrun_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        do_lit(10, 128, 0);

        // Back-to-back stream with in_valid held high.
        b2b = '{5, 10, 77, 200, 3};
        for (int i = 0; i < 5; i++) send(b2b[i], i < 4);
        drain();

        // Full operand sweep in random order with random consumer stalls.
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j        = int'($urandom_range(i, 0));
            t        = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        rand_ready = 1'b1;
        for (int i = 0; i < 256; i++) send(order[i], 1'b0);
        drain();
        rand_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
